// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: sequential AES-128 key schedule sharing one external byte S-box
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             start request, sampled only in IDLE
//   key_in[127:0]     cipher key, [127:96]=w0 .. [31:0]=w3
//   sbox_in[7:0]      byte presented to the shared combinational S-box
//   sbox_out[7:0]     S-box result for sbox_in in the same cycle
//   busy              high while a schedule runs
//   rk_valid          one-cycle strobe for rk_idx/rk_data
//   rk_idx[3:0]       round index 0..10
//   rk_data[127:0]    round key, same order as key_in
//   done              one-cycle pulse with the round-10 strobe
//   rd_idx[3:0]       (KEY_EXP_STORE_EN) round-key bank read index
//   rd_data[127:0]    (KEY_EXP_STORE_EN) combinational bank read, 0 for rd_idx > 10
//
// Optional feature macro: KEY_EXP_STORE_EN adds an 11 x 128 round-key bank.
module key_expand_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         done
`ifdef KEY_EXP_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data
`endif
);
    typedef enum logic [1:0] {IDLE, SUB, UPD} state_t;
    state_t       state_q;
    logic [127:0] w_q, w_d, rk_data_q;
    logic [31:0]  temp_q, t, w0_d, w1_d, w2_d, w3_d;
    logic [1:0]   k_q;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         busy_q, rk_valid_q, done_q;
`ifdef KEY_EXP_STORE_EN
    logic [127:0] bank_q [0:NR];
`endif
    always_comb begin
        t        = temp_q ^ {rcon_q, 24'h0};
        w0_d     = w_q[127:96] ^ t;
        w1_d     = w_q[95:64] ^ w0_d;
        w2_d     = w_q[63:32] ^ w1_d;
        w3_d     = w_q[31:0] ^ w2_d;
        w_d      = {w0_d, w1_d, w2_d, w3_d};
        rk_idx_d = rk_idx_q + 4'd1;
        rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        // RotWord(w3) byte k; held at zero outside SUB so the S-box stays quiet
        sbox_in  = (state_q != SUB) ? 8'h00 :
                   (k_q == 2'd0)    ? w_q[23:16] :
                   (k_q == 2'd1)    ? w_q[15:8] :
                   (k_q == 2'd2)    ? w_q[7:0] : w_q[31:24];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            w_q        <= '0;
            temp_q     <= '0;
            k_q        <= '0;
            rcon_q     <= 8'h01;
            rk_idx_q   <= '0;
            rk_data_q  <= '0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef KEY_EXP_STORE_EN
            for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
`endif
        end else begin
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    w_q        <= key_in;
                    rcon_q     <= 8'h01;
                    k_q        <= '0;
                    busy_q     <= 1'b1;
                    rk_valid_q <= 1'b1;
                    rk_idx_q   <= '0;
                    rk_data_q  <= key_in;
                    state_q    <= SUB;
`ifdef KEY_EXP_STORE_EN
                    bank_q[0]  <= key_in;
`endif
                end
                SUB: begin
                    // shifting in four bytes leaves byte 0 in temp[31:24]
                    temp_q  <= {temp_q[23:0], sbox_out};
                    k_q     <= k_q + 2'd1;
                    state_q <= (k_q == 2'd3) ? UPD : SUB;
                end
                UPD: begin
                    w_q        <= w_d;
                    rcon_q     <= rcon_d;
                    rk_valid_q <= 1'b1;
                    rk_idx_q   <= rk_idx_d;
                    rk_data_q  <= w_d;
                    done_q     <= (rk_idx_d == 4'(NR));
                    busy_q     <= (rk_idx_d != 4'(NR));
                    state_q    <= (rk_idx_d == 4'(NR)) ? IDLE : SUB;
`ifdef KEY_EXP_STORE_EN
                    bank_q[rk_idx_d] <= w_d;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_idx   = rk_idx_q;
    assign rk_data  = rk_data_q;
    assign done     = done_q;
`ifdef KEY_EXP_STORE_EN
    assign rd_data  = (rd_idx <= 4'(NR)) ? bank_q[rd_idx] : '0;
`endif
endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb_key_expand_ctrl: randomized self-checking bench against a word-level AES key-expansion model
module tb_key_expand_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [7:0]   sbox_in, sbox_out;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
`ifdef KEY_EXP_STORE_EN
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_data;
`endif
    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got [0:10];
    logic [7:0]   sb_seen [0:3];
    logic [31:0]  temp_seen;
    int errors = 0;
    int checks = 0;

    key_expand_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy),
        .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_data(rk_data), .done(done)
`ifdef KEY_EXP_STORE_EN
        , .rd_idx(rd_idx), .rd_data(rd_data)
`endif
    );

    assign sbox_out = sbox_tab[sbox_in];
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required below 200000", $time);
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [7:0]  rc [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/4 - 1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Starts one schedule and checks every cycle of it against the model.
    // pulse_at: edge number at which an extra start is offered mid-run (-1 none).
    // hold: keep start high through done and check the immediate restart.
    task automatic run_sched(input logic [127:0] key, input int pulse_at, input bit hold);
        int strobes = 0;
        model(key);
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        for (int c = 0; c <= 54; c++) begin
            @(negedge clk);
            if (hold && c == 51) begin
                checks++;
                if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_data !== key_in || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL held_start_restart: valid=%b idx=%0d data=%h busy=%b required valid=1 idx=0 data=%h busy=1",
                             rk_valid, rk_idx, rk_data, busy, key_in);
                end
                break;
            end
            if (c <= 50) begin
                int r = c / 5;
                int j = c % 5;
                logic [31:0] w3  = exp_rk[r][31:0];
                logic [31:0] rot = {w3[23:0], w3[31:24]};
                logic [7:0]  esb = (c < 50 && j < 4) ? rot[31 - 8*j -: 8] : 8'h00;
                checks++;
                if (rk_valid !== (j == 0)) begin
                    errors++;
                    $display("FAIL rk_valid c=%0d: got %b required %b", c, rk_valid, j == 0);
                end
                checks++;
                if (done !== (c == 50)) begin
                    errors++;
                    $display("FAIL done c=%0d: got %b required %b", c, done, c == 50);
                end
                checks++;
                if (busy !== (c < 50)) begin
                    errors++;
                    $display("FAIL busy c=%0d: got %b required %b", c, busy, c < 50);
                end
                checks++;
                if (sbox_in !== esb) begin
                    errors++;
                    $display("FAIL sbox_in c=%0d: got %h required %h", c, sbox_in, esb);
                end
                if (j == 0) begin
                    got[r] = rk_data;
                    checks++;
                    if (rk_idx !== 4'(r) || rk_data !== exp_rk[r]) begin
                        errors++;
                        $display("FAIL round_key c=%0d: idx=%0d data=%h required idx=%0d data=%h",
                                 c, rk_idx, rk_data, r, exp_rk[r]);
                    end
                end
                if (j == 4) begin
                    checks++;
                    if (dut.temp_q !== sub_word(rot)) begin
                        errors++;
                        $display("FAIL temp_at_upd c=%0d: got %h required %h", c, dut.temp_q, sub_word(rot));
                    end
                end
            end else begin
                checks++;
                if (rk_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd10 || rk_data !== exp_rk[10]) begin
                    errors++;
                    $display("FAIL after_done c=%0d: valid=%b done=%b busy=%b idx=%0d data=%h required 0 0 0 10 %h",
                             c, rk_valid, done, busy, rk_idx, rk_data, exp_rk[10]);
                end
            end
            if (c < 4) sb_seen[c] = sbox_in;
            if (c == 4) temp_seen = dut.temp_q;
            if (rk_valid) strobes++;
            key_in = {$urandom, $urandom, $urandom, $urandom};
            start  = hold || (c == pulse_at - 1);
        end
        start = 1'b0;
        if (!hold) begin
            checks++;
            if (strobes != 11) begin
                errors++;
                $display("FAIL strobe_count: got %0d required 11", strobes);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || rk_idx !== 4'd0 || rk_data !== '0 || sbox_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b done=%b idx=%0d data=%h sbox_in=%h required all 0",
                     busy, rk_valid, done, rk_idx, rk_data, sbox_in);
        end
`ifdef KEY_EXP_STORE_EN
        rd_idx = 4'd3;
        #1;
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL bank_reset: got %h required 0", rd_data);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, rk_valid);
        end
    endtask

    task automatic test_fips();
        logic [7:0] sb_exp [0:3] = '{8'hcf, 8'h4f, 8'h3c, 8'h09};
        run_sched(FIPS, -1, 1'b0);
        checks++;
        if (got[0] !== FIPS) begin
            errors++;
            $display("FAIL fips_idx0: got %h required %h", got[0], FIPS);
        end
        checks++;
        if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_idx1: got %h required a0fafe1788542cb123a339392a6c7605", got[1]);
        end
        checks++;
        if (got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_idx10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sb_seen[i] !== sb_exp[i]) begin
                errors++;
                $display("FAIL fips_sbox_in[%0d]: got %h required %h", i, sb_seen[i], sb_exp[i]);
            end
        end
        checks++;
        if (temp_seen !== 32'h8a84eb01) begin
            errors++;
            $display("FAIL fips_temp: got %h required 8a84eb01", temp_seen);
        end
`ifdef KEY_EXP_STORE_EN
        rd_idx = 4'd1;
        #1;
        checks++;
        if (rd_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL bank_idx1: got %h required a0fafe1788542cb123a339392a6c7605", rd_data);
        end
        rd_idx = 4'd10;
        #1;
        checks++;
        if (rd_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL bank_idx10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", rd_data);
        end
        rd_idx = 4'd15;
        #1;
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL bank_idx15: got %h required 0", rd_data);
        end
        rd_idx = 4'd0;
        #1;
        checks++;
        if (rd_data !== FIPS) begin
            errors++;
            $display("FAIL bank_idx0: got %h required %h", rd_data, FIPS);
        end
`endif
    endtask

    task automatic test_zero_key();
        run_sched('0, -1, 1'b0);
        checks++;
        if (got[1] !== 128'h62636363626363636263636362636363) begin
            errors++;
            $display("FAIL zero_idx1: got %h required 62636363626363636263636362636363", got[1]);
        end
        checks++;
        if (got[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_idx10: got %h required b4ef5bcb3e92e21123e951cf6f8f188e", got[10]);
        end
    endtask

    task automatic test_start_while_busy();
        run_sched({$urandom, $urandom, $urandom, $urandom}, 20, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit idle = 1'b0;
        run_sched({$urandom, $urandom, $urandom, $urandom}, -1, 1'b1);
        for (int c = 0; c < 60 && !idle; c++) begin
            @(negedge clk);
            idle = !busy;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL back_to_back_finish: busy still %b after 60 cycles required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        bit any_done = 1'b0;
        @(negedge clk);
        key_in = FIPS;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (rk_valid && rk_idx == 4'd4) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reset_idx4: strobe idx4 seen=%b required 1", seen);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || rk_idx !== 4'd0 || rk_data !== '0 || sbox_in !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b valid=%b done=%b idx=%0d data=%h sbox_in=%h required all 0",
                     busy, rk_valid, done, rk_idx, rk_data, sbox_in);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            any_done |= done | busy;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            any_done |= done | busy | rk_valid;
        end
        checks++;
        if (any_done) begin
            errors++;
            $display("FAIL mid_reset_quiet: done/busy/valid seen=%b required 0", any_done);
        end
        run_sched(FIPS, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) run_sched({$urandom, $urandom, $urandom, $urandom}, -1, 1'b0);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
